// File: rtl/hex_scan_display.sv
// Time-multiplexed 7-segment driver for DIGITS hex nibbles with frame-aligned value update.
// Optional decimal-point support is enabled by defining HEX_SCAN_DP_EN.
module hex_scan_display #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] Value,
    input  logic                LzbEn,
`ifdef HEX_SCAN_DP_EN
    input  logic [DIGITS-1:0]   DpIn,
    output logic                Dp,
`endif
    output logic [0:6]          Seg,
    output logic [DIGITS-1:0]   DigitSel,
    output logic                Pending
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [PW-1:0]     prescaler;
    logic [IW-1:0]     index;
    logic [VW-1:0]     pend_value;
    logic [VW-1:0]     active_value;
    logic              tick_c;
    logic              boundary_c;
    logic [3:0]        nibble_c;
    logic              lz_run_c;
    logic              lead_c;
    logic              blank_c;
    logic [0:6]        seg_c;
    logic [DIGITS-1:0] sel_c;
`ifdef HEX_SCAN_DP_EN
    logic [DIGITS-1:0] pend_dp;
    logic [DIGITS-1:0] active_dp;
    logic              dp_c;
`endif

    function automatic logic [0:6] seg_decode(input logic [3:0] nib);
        logic [0:6] pat;
        case (nib)
            4'h0: pat = 7'b0000001;
            4'h1: pat = 7'b1001111;
            4'h2: pat = 7'b0010010;
            4'h3: pat = 7'b0000110;
            4'h4: pat = 7'b1001100;
            4'h5: pat = 7'b0100100;
            4'h6: pat = 7'b0100000;
            4'h7: pat = 7'b0001111;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0001100;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b1100000;
            4'hC: pat = 7'b0110001;
            4'hD: pat = 7'b1000010;
            4'hE: pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

    assign tick_c     = (prescaler == PW'(CLK_DIV - 1));
    assign boundary_c = tick_c && (index == IW'(DIGITS - 1));

    // Slot timing: prescaler sets slot length, index walks the digits.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            if (tick_c) begin
                prescaler <= '0;
                if (index == IW'(DIGITS - 1)) begin
                    index <= '0;
                end else begin
                    index <= index + IW'(1);
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Load goes to the holding register; commit only at a frame boundary uses the pre-edge value.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            pend_value   <= '0;
            active_value <= '0;
            Pending      <= 1'b0;
        end else begin
            if (boundary_c && Pending) begin
                active_value <= pend_value;
            end
            if (Load) begin
                pend_value <= Value;
                Pending    <= 1'b1;
            end else if (boundary_c) begin
                Pending <= 1'b0;
            end
        end
    end

`ifdef HEX_SCAN_DP_EN
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            pend_dp   <= '0;
            active_dp <= '0;
        end else begin
            if (boundary_c && Pending) begin
                active_dp <= pend_dp;
            end
            if (Load) begin
                pend_dp <= DpIn;
            end
        end
    end
`endif

    // Select the current digit and track whether it is within the run of leading zeros.
    always_comb begin
        nibble_c = '0;
        lz_run_c = 1'b1;
        lead_c   = 1'b0;
        sel_c    = '1;
`ifdef HEX_SCAN_DP_EN
        dp_c     = 1'b1;
`endif
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef HEX_SCAN_DP_EN
            lz_run_c = lz_run_c && (active_value[4*i +: 4] == 4'h0) && !active_dp[i];
`else
            lz_run_c = lz_run_c && (active_value[4*i +: 4] == 4'h0);
`endif
            if (index == IW'(i)) begin
                nibble_c = active_value[4*i +: 4];
                lead_c   = lz_run_c;
                sel_c[i] = tick_c;
`ifdef HEX_SCAN_DP_EN
                dp_c     = ~active_dp[i];
`endif
            end
        end
        blank_c = LzbEn && (index != '0) && lead_c;
        seg_c   = blank_c ? 7'b1111111 : seg_decode(nibble_c);
    end

    // Registered pin drivers; DigitSel is forced off on the last cycle of each slot.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Seg      <= 7'b1111111;
            DigitSel <= '1;
`ifdef HEX_SCAN_DP_EN
            Dp       <= 1'b1;
`endif
        end else begin
            Seg      <= seg_c;
            DigitSel <= sel_c;
`ifdef HEX_SCAN_DP_EN
            Dp       <= dp_c;
`endif
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display with DIGITS=4, CLK_DIV=4.
module tb_hex_scan_display;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CLK_DIV = 4;

    logic              Clk;
    logic              ResetN;
    logic              Load;
    logic [15:0]       Value;
    logic              LzbEn;
    logic [0:6]        Seg;
    logic [3:0]        DigitSel;
    logic              Pending;
`ifdef HEX_SCAN_DP_EN
    logic [3:0]        DpIn;
    logic              Dp;
`endif

    hex_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Load     (Load),
        .Value    (Value),
        .LzbEn    (LzbEn),
`ifdef HEX_SCAN_DP_EN
        .DpIn     (DpIn),
        .Dp       (Dp),
`endif
        .Seg      (Seg),
        .DigitSel (DigitSel),
        .Pending  (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0]     value;
        logic            lzb;
        logic [3:0][6:0] pat;   // pat[i] = expected a..g of digit i
    } vec_t;

    vec_t            vecs [8];
    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;
    logic [3:0][6:0] exp_pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Outputs after edge n reflect slot state after edge n-1: phase (n-1)%4, digit ((n-1)/4)%4.
    task automatic tick_chk(input string name);
        int         ph;
        int         id;
        logic [3:0] esel;
        logic [6:0] seg_v;
        @(posedge Clk);
        #1;
        cyc++;
        ph    = (cyc - 1) % 4;
        id    = ((cyc - 1) / 4) % 4;
        esel  = (ph == 3) ? 4'hF : ~(4'b0001 << id);
        seg_v = Seg;
        chk({name, "_seg"}, 32'(seg_v), 32'(exp_pat[id]));
        chk({name, "_sel"}, 32'(DigitSel), 32'(esel));
    endtask

    task automatic run_until(input string name, input int phase);
        do begin
            tick_chk(name);
        end while ((cyc % 16) != phase);
    endtask

    task automatic load_value(input string name, input logic [15:0] v);
        Load  = 1'b1;
        Value = v;
        tick_chk(name);
        Load  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h3A5F, 1'b0, {7'b0000110, 7'b0001000, 7'b0100100, 7'b0111000}};
        vecs[1] = '{16'h00C0, 1'b1, {7'b1111111, 7'b1111111, 7'b0110001, 7'b0000001}};
        vecs[2] = '{16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        vecs[3] = '{16'h1234, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[4] = '{16'hCB98, 1'b0, {7'b0110001, 7'b1100000, 7'b0001100, 7'b0000000}};
        vecs[5] = '{16'hFED6, 1'b0, {7'b0111000, 7'b0110000, 7'b1000010, 7'b0100000}};
        vecs[6] = '{16'h0700, 1'b1, {7'b1111111, 7'b0001111, 7'b0000001, 7'b0000001}};
        vecs[7] = '{16'h00C0, 1'b0, {7'b0000001, 7'b0000001, 7'b0110001, 7'b0000001}};

        ResetN  = 1'b0;
        Load    = 1'b0;
        Value   = '0;
        LzbEn   = 1'b0;
`ifdef HEX_SCAN_DP_EN
        DpIn    = '0;
`endif
        exp_pat = {4{7'b0000001}};

        #12;
        chk("reset_seg", 32'({Seg}), 32'h7F);
        chk("reset_sel", 32'(DigitSel), 32'hF);
        chk("reset_pending", 32'(Pending), 32'h0);
        @(negedge Clk);
        ResetN = 1'b1;
        cyc    = 0;

        repeat (20) tick_chk("idle");

        // Mid-frame load of each vector; old frame finishes, new value live from the boundary.
        for (int v = 0; v < 8; v++) begin
            run_until("old_frame", 5);
            load_value("load", vecs[v].value);
            chk("pending_set", 32'(Pending), 32'h1);
            run_until("old_frame", 0);
            chk("pending_clr", 32'(Pending), 32'h0);
            exp_pat = vecs[v].pat;
            LzbEn   = vecs[v].lzb;
        end
        run_until("last_vec", 0);

        // Two loads in one frame: only the second is ever shown.
        LzbEn = 1'b0;
        run_until("dbl_pre", 3);
        load_value("dbl_load1", 16'h1111);
        chk("dbl_pending", 32'(Pending), 32'h1);
        run_until("dbl_pre", 8);
        load_value("dbl_load2", 16'h2222);
        run_until("dbl_pre", 0);
        chk("dbl_pending_clr", 32'(Pending), 32'h0);
        exp_pat = {4{7'b0010010}};

        // Load on the boundary edge: pending 00C0 commits, 4444 waits a frame.
        run_until("bnd_pre", 5);
        load_value("bnd_load1", 16'h00C0);
        run_until("bnd_pre", 15);
        load_value("bnd_load2", 16'h4444);
        chk("bnd_pending_held", 32'(Pending), 32'h1);
        exp_pat = vecs[7].pat;
        run_until("bnd_mid", 8);
        chk("bnd_pending_mid", 32'(Pending), 32'h1);
        run_until("bnd_mid", 0);
        chk("bnd_pending_clr", 32'(Pending), 32'h0);
        exp_pat = {4{7'b1001100}};
        run_until("bnd_new", 0);

        // Asynchronous reset mid-slot with a load pending.
        run_until("rst_pre", 5);
        load_value("rst_load", 16'h8888);
        chk("rst_pending_set", 32'(Pending), 32'h1);
        #2;
        ResetN = 1'b0;
        #1;
        chk("async_rst_seg", 32'({Seg}), 32'h7F);
        chk("async_rst_sel", 32'(DigitSel), 32'hF);
        chk("async_rst_pending", 32'(Pending), 32'h0);
        @(posedge Clk);
        #1;
        chk("held_rst_sel", 32'(DigitSel), 32'hF);
        @(negedge Clk);
        ResetN  = 1'b1;
        cyc     = 0;
        exp_pat = {4{7'b0000001}};
        repeat (20) tick_chk("post_reset");
        chk("post_reset_pending", 32'(Pending), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
- Multi-digit, time-multiplexed 7-segment driver for DIGITS hex nibbles.
- Latches a packed value on a load strobe; the new value goes live only at a frame boundary, so a frame never mixes old and new digits.
- One digit is enabled per refresh slot. Optional leading-zero blanking.
- Sits between datapath result registers and the board's common-segment display pins.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 50000: clock cycles per digit slot; minimum 2.

Ports:
- Clk  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Load  in  1  capture Value this cycle.
- Value  in  4*DIGITS  packed nibbles; digit i = Value[4i+3:4i], digit 0 rightmost.
- LzbEn  in  1  leading-zero blanking enable, sampled live.
- Seg  out  [0:6]  segments a..g, Seg[0]=a; 0 = segment on.
- DigitSel  out  DIGITS  one-hot-low digit enable; DigitSel[i]=0 drives digit i.
- Pending  out  1  loaded value waiting for frame boundary.

Behaviour:
- Reset (async assert, sync release): prescaler=0, index=0, pending reg=0, active reg=0, Pending=0, Seg=7'b1111111, DigitSel=all ones.
- Prescaler: counts 0..CLK_DIV-1 and wraps. Tick = (prescaler==CLK_DIV-1).
- Index: advances on Tick, wrapping DIGITS-1 -> 0. Frame boundary = Tick && index==DIGITS-1.
- Load=1: pending reg <= Value, Pending <= 1. Repeated loads before a boundary: last wins.
- At frame boundary with Pending=1: active <= pending reg, Pending <= 0.
- Load coincident with boundary: commit uses the pre-edge pending reg. The new Value enters the pending reg and Pending stays 1.
- Outputs are registered and updated every cycle from the current index and active reg, so latency is 1 cycle from an index change.
- Dead time: on the cycle where the registered prescaler equals CLK_DIV-1, the next DigitSel is all ones (anti-ghosting). Seg still carries that slot's pattern.
- Segment patterns, a..g, 0=on:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0001100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Blanking (LzbEn=1): digit i>0 is blank if it and every digit above it are 0. Digit 0 is never blanked, so all-zero shows "0". Blank digit: Seg=1111111 with DigitSel still asserted.
- DIGITS=1: index is constant 0 and every Tick is a boundary.
- Reset mid-frame: a pending load is discarded and the display restarts at digit 0 showing 0.

Optional Feature:
- Macro HEX_SCAN_DP_EN.
- Defined:
  - Adds input DpIn [DIGITS-1:0] and output Dp (1 bit, 0 = on).
  - DpIn is latched alongside Value on Load and committed at the same boundary.
  - Dp = ~active DpIn[index], registered with Seg; reset Dp=1.
  - A blanked digit with its DP bit set still lights Dp and is not blanked as a leading zero.
- Undefined: no DpIn or Dp ports and no DP storage; behaviour otherwise identical.

Test Plan (DIGITS=4, CLK_DIV=4):
- Reset, then 20 cycles, no Load -> Seg=0000001 (0) on digits 0..3 in order; DigitSel 1110,1101,1011,0111; all ones on each slot's last cycle.
- Load Value=16'h3A5F mid-frame -> Pending=1; old digits continue until the index 3 -> 0 wrap; then digit0=F 0111000, digit1=5 0100100, digit2=A 0001000, digit3=3 0000110; Pending=0.
- Load 16'h1111 then 16'h2222 within one frame -> only 2 (0010010) is ever displayed; 1 never appears.
- Load asserted on the boundary cycle with pending 16'h00C0 -> 0,C,0,0 go live at this boundary; the new value goes live one frame later; Pending stays 1 in between.
- LzbEn=1, Value=16'h00C0 -> digits 3 and 2 Seg=1111111, digit1=0110001, digit0=0000001. Value=0 -> only digit 0 lit with 0.
- ResetN pulsed low mid-slot with Pending=1 -> outputs go all-ones immediately without a clock edge; Pending=0; after release digit 0 shows 0.
